mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width.
REQ-002 Parameter ADDRESS_WIDTH, default 32, address width.
REQ-003 Parameter MSG_BITS, default 3, message code width.
REQ-004 Parameter WB_DEPTH, default 2, write-back buffer entries (power of two, >=2).
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 c_valid  in  1  cache request valid.
REQ-008 c_write  in  1  1 = write-back, 0 = read.
REQ-009 c_address  in  ADDRESS_WIDTH  request address.
REQ-010 c_data  in  DATA_WIDTH  write-back data.
REQ-011 c_ready  out  1  request accepted this cycle when high with c_valid.
REQ-012 c_rvalid  out  1  one-cycle pulse, read data valid.
REQ-013 c_rdata  out  DATA_WIDTH  read data.
REQ-014 c_raddress  out  ADDRESS_WIDTH  address of returned read.
REQ-015 msg_out  out  MSG_BITS  request code to main memory (NO_REQ, R_REQ, WB_REQ).
REQ-016 address_out  out  ADDRESS_WIDTH  address to main memory.
REQ-017 data_out  out  DATA_WIDTH  write data to main memory.
REQ-018 msg_in  in  MSG_BITS  memory response (MEM_NO_MSG, MEM_READY, MEM_SENT).
REQ-019 address_in  in  ADDRESS_WIDTH  memory response address.
REQ-020 data_in  in  DATA_WIDTH  memory read data, valid only in the MEM_SENT cycle.

Function
REQ-021 FSM states: IDLE, RD_WAIT, WB_WAIT; msg_out, address_out and data_out are registered.
REQ-022 Write-back accepted (c_ready=1) whenever the buffer is not full, in any state; a full buffer gives c_ready=0 for writes, with no same-cycle enqueue/drain bypass.
REQ-023 Read accepted only in IDLE and only with no read outstanding.
REQ-024 Read whose address matches a buffered entry is forwarded from the youngest matching entry; c_rvalid is asserted the cycle after acceptance, with no memory transaction.
REQ-025 Read miss in IDLE: next cycle msg_out=R_REQ with address_out=c_address; enter RD_WAIT.
REQ-026 RD_WAIT: hold R_REQ until msg_in==MEM_SENT; capture data_in and address_in that cycle.
REQ-027 Read miss latency: c_rvalid one cycle after the MEM_SENT cycle.
REQ-028 On the edge after MEM_SENT, msg_out returns to NO_REQ or the next request; no idle gap is required.
REQ-029 IDLE with buffer non-empty and no read accepted: drive WB_REQ with the oldest entry's address and data; enter WB_WAIT.
REQ-030 Read acceptance has priority over starting a drain in the same IDLE cycle.
REQ-031 WB_WAIT: hold WB_REQ until msg_in==MEM_READY; pop the oldest entry on that edge; return to IDLE.
REQ-032 Buffer is FIFO ordered; writes to the same address allocate new entries with no merging, and drain in order.
REQ-033 The oldest entry stays searchable for forwarding until it is popped.
REQ-034 Responses in the wrong state, or MEM_SENT with address_in differing from the outstanding address, are ignored.
REQ-035 Buffer pointers wrap modulo WB_DEPTH; a count register of width log2(WB_DEPTH)+1 distinguishes full from empty.

Reset
REQ-036 Reset assertion immediately forces IDLE, msg_out=NO_REQ, address_out=0, data_out=0, c_rvalid=0, c_rdata=0, c_raddress=0 and an empty buffer.
REQ-037 Reset mid-transaction discards outstanding reads and all buffered write-backs.
REQ-038 Deassertion is synchronised externally; the first active edge after deassertion may accept requests.

Structure
REQ-039 Message codes (NO_REQ, R_REQ, WB_REQ, MEM_NO_MSG, MEM_READY, MEM_SENT) come from the shared params.v include; no local redefinition.
REQ-040 The write-back buffer is sub-module wb_buffer: FIFO with push/pop, full/empty, and a youngest-match address search returning hit and data.
REQ-041 The FSM and memory-side registers live in mem_requester.

Verification
REQ-042 Read 0x100, memory returns MEM_SENT with data 0xDEADBEEF three cycles later -> c_rvalid one cycle after MEM_SENT, c_rdata=0xDEADBEEF, c_raddress=0x100.
REQ-043 Write 0x200/0x11 then read 0x200 -> forwarded 0x11 next cycle; no R_REQ driven.
REQ-044 Writes 0x10/0xA, 0x10/0xB, then read 0x10 -> returns 0xB; drains to memory in order 0xA then 0xB.
REQ-045 WB_DEPTH=2, three back-to-back writes with MEM_READY withheld -> c_ready=0 on the third write until the first MEM_READY pops an entry.
REQ-046 Reset asserted while in RD_WAIT with two buffered entries -> msg_out=NO_REQ immediately, buffer empty, late MEM_SENT ignored.
REQ-047 Read miss and non-empty buffer in the same IDLE cycle -> R_REQ is driven first; WB_REQ follows the cycle after MEM_SENT.

Source files
------------

// File: rtl/mem_requester_pkg.sv
// Shared definitions for the memory requester: message codes and FSM state type.
package mem_requester_pkg;

  // Requester -> memory codes
  localparam logic [2:0] NO_REQ     = 3'd0;
  localparam logic [2:0] R_REQ      = 3'd1;
  localparam logic [2:0] WB_REQ     = 3'd2;

  // Memory -> requester codes
  localparam logic [2:0] MEM_NO_MSG = 3'd0;
  localparam logic [2:0] MEM_READY  = 3'd1;
  localparam logic [2:0] MEM_SENT   = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WB_WAIT
  } state_t;

endpackage

// File: rtl/wb_buffer.sv
// Write-back FIFO with a parallel youngest-match address search used for
// read forwarding; entries stay searchable until popped.
module wb_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_address,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  input  logic [ADDRESS_WIDTH-1:0] search_address,
  output logic                     full,
  output logic                     empty,
  output logic [ADDRESS_WIDTH-1:0] head_address,
  output logic [DATA_WIDTH-1:0]    head_data,
  output logic                     hit,
  output logic [DATA_WIDTH-1:0]    hit_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic [PTR_W-1:0]         rd_ptr_reg;
  logic [PTR_W:0]           count_reg;
  logic                     push_ok;
  logic                     pop_ok;

  assign full         = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty        = (count_reg == '0);
  assign push_ok      = push && !full;
  assign pop_ok       = pop && !empty;
  assign head_address = addr_mem[rd_ptr_reg];
  assign head_data    = data_mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      addr_mem[wr_ptr_reg] <= push_address;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  logic [PTR_W-1:0] slot_age [DEPTH];
  logic [DEPTH-1:0] slot_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_age[gi]   = PTR_W'(gi) - rd_ptr_reg;
      assign slot_match[gi] = ({1'b0, slot_age[gi]} < count_reg) &&
                              (addr_mem[gi] == search_address);
    end
  endgenerate

  // Larger age means pushed later, so the highest matching age is the youngest.
  logic [PTR_W-1:0] best_age;
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_match[i] && (!hit || slot_age[i] > best_age)) begin
        hit      = 1'b1;
        best_age = slot_age[i];
        hit_data = data_mem[i];
      end
    end
  end

endmodule

// File: rtl/mem_requester.sv
// Cache-to-memory requester: serves reads (forwarded from the write-back
// buffer when possible) and drains buffered write-backs to main memory.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MSG_BITS      = 3,
  parameter int WB_DEPTH      = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     c_valid,
  input  logic                     c_write,
  input  logic [ADDRESS_WIDTH-1:0] c_address,
  input  logic [DATA_WIDTH-1:0]    c_data,
  output logic                     c_ready,
  output logic                     c_rvalid,
  output logic [DATA_WIDTH-1:0]    c_rdata,
  output logic [ADDRESS_WIDTH-1:0] c_raddress,
  output logic [MSG_BITS-1:0]      msg_out,
  output logic [ADDRESS_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  input  logic [MSG_BITS-1:0]      msg_in,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]    data_in
);

  state_t                   state_reg;
  logic                     wb_full, wb_empty, wb_hit;
  logic [ADDRESS_WIDTH-1:0] wb_head_address;
  logic [DATA_WIDTH-1:0]    wb_head_data, wb_hit_data;
  logic                     read_accept, wb_push, wb_pop, sent_ok;

  assign c_ready     = c_write ? !wb_full : (state_reg == IDLE);
  assign read_accept = c_valid && !c_write && (state_reg == IDLE);
  assign wb_push     = c_valid && c_write && !wb_full;
  assign wb_pop      = (state_reg == WB_WAIT) && (msg_in == MSG_BITS'(MEM_READY));
  // address_out still holds the outstanding read address while in RD_WAIT
  assign sent_ok     = (state_reg == RD_WAIT) && (msg_in == MSG_BITS'(MEM_SENT)) &&
                       (address_in == address_out);

  wb_buffer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DEPTH        (WB_DEPTH)
  ) u_wb_buffer (
    .clock         (clock),
    .reset         (reset),
    .push          (wb_push),
    .push_address  (c_address),
    .push_data     (c_data),
    .pop           (wb_pop),
    .search_address(c_address),
    .full          (wb_full),
    .empty         (wb_empty),
    .head_address  (wb_head_address),
    .head_data     (wb_head_data),
    .hit           (wb_hit),
    .hit_data      (wb_hit_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      msg_out     <= MSG_BITS'(NO_REQ);
      address_out <= '0;
      data_out    <= '0;
      c_rvalid    <= 1'b0;
      c_rdata     <= '0;
      c_raddress  <= '0;
    end else begin
      c_rvalid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (read_accept && wb_hit) begin
            c_rvalid   <= 1'b1;
            c_rdata    <= wb_hit_data;
            c_raddress <= c_address;
            msg_out    <= MSG_BITS'(NO_REQ);
          end else if (read_accept) begin
            msg_out     <= MSG_BITS'(R_REQ);
            address_out <= c_address;
            state_reg   <= RD_WAIT;
          end else if (!wb_empty) begin
            msg_out     <= MSG_BITS'(WB_REQ);
            address_out <= wb_head_address;
            data_out    <= wb_head_data;
            state_reg   <= WB_WAIT;
          end else begin
            msg_out <= MSG_BITS'(NO_REQ);
          end
        end
        RD_WAIT: begin
          if (sent_ok) begin
            c_rvalid   <= 1'b1;
            c_rdata    <= data_in;
            c_raddress <= address_in;
            // Chain straight into a drain so no idle cycle is wasted.
            if (!wb_empty) begin
              msg_out     <= MSG_BITS'(WB_REQ);
              address_out <= wb_head_address;
              data_out    <= wb_head_data;
              state_reg   <= WB_WAIT;
            end else begin
              msg_out   <= MSG_BITS'(NO_REQ);
              state_reg <= IDLE;
            end
          end
        end
        WB_WAIT: begin
          if (wb_pop) begin
            msg_out   <= MSG_BITS'(NO_REQ);
            state_reg <= IDLE;
          end
        end
        default: begin
          msg_out   <= MSG_BITS'(NO_REQ);
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized + directed bench for mem_requester against a queue-based
// transaction model of the requester.
module tb_mem_requester;
  import mem_requester_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c_valid = 1'b0, c_write = 1'b0;
  logic [31:0] c_address = '0, c_data = '0;
  logic        c_ready, c_rvalid;
  logic [31:0] c_rdata, c_raddress;
  logic [2:0]  msg_out;
  logic [31:0] address_out, data_out;
  logic [2:0]  msg_in = MEM_NO_MSG;
  logic [31:0] address_in = '0, data_in = '0;

  always #5 clock = ~clock;

  mem_requester #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MSG_BITS(3), .WB_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .c_valid(c_valid), .c_write(c_write), .c_address(c_address), .c_data(c_data),
    .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_raddress(c_raddress),
    .msg_out(msg_out), .address_out(address_out), .data_out(data_out),
    .msg_in(msg_in), .address_in(address_in), .data_in(data_in)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending memory op (0 none, 1 read, 2 write-back), expected outputs,
  // buffered write-backs in arrival order, and the order entries were drained.
  int          m_wait = 0;
  logic [2:0]  e_msg = NO_REQ;
  logic [31:0] e_addr = '0, e_data = '0;
  logic        e_rvalid = 1'b0;
  logic [31:0] e_rdata = '0, e_raddr = '0;
  logic [31:0] mq_a[$];
  logic [31:0] mq_d[$];
  logic [31:0] drain_log[$];
  logic        last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_drain();
    e_msg  = WB_REQ;
    e_addr = mq_a[0];
    e_data = mq_d[0];
    m_wait = 2;
  endtask

  // One clock cycle: drive inputs at the falling edge, predict, then compare.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] mi, input logic [31:0] ai, input logic [31:0] di);
    logic rdy_exp;
    logic hit;
    logic [31:0] hd;
    bit had_entries;
    c_valid = v; c_write = w; c_address = a; c_data = d;
    msg_in = mi; address_in = ai; data_in = di;
    #1;
    last_ready = c_ready;
    rdy_exp = w ? (mq_a.size() < DEPTH) : (m_wait == 0);
    if (v) chk("c_ready", 32'(c_ready), 32'(rdy_exp));
    had_entries = (mq_a.size() != 0);
    e_rvalid = 1'b0;
    case (m_wait)
      0: begin
        if (v && !w) begin
          hit = 1'b0; hd = '0;
          for (int i = mq_a.size() - 1; i >= 0; i--) begin
            if (mq_a[i] == a) begin hit = 1'b1; hd = mq_d[i]; break; end
          end
          if (hit) begin
            e_rvalid = 1'b1; e_rdata = hd; e_raddr = a; e_msg = NO_REQ;
          end else begin
            e_msg = R_REQ; e_addr = a; m_wait = 1;
          end
        end else if (had_entries) start_drain();
        else e_msg = NO_REQ;
      end
      1: begin
        if (mi == MEM_SENT && ai == e_addr) begin
          e_rvalid = 1'b1; e_rdata = di; e_raddr = ai;
          if (had_entries) start_drain();
          else begin e_msg = NO_REQ; m_wait = 0; end
        end
      end
      default: begin
        if (mi == MEM_READY) begin
          drain_log.push_back(mq_d[0]);
          void'(mq_a.pop_front());
          void'(mq_d.pop_front());
          e_msg = NO_REQ; m_wait = 0;
        end
      end
    endcase
    if (v && w && rdy_exp) begin mq_a.push_back(a); mq_d.push_back(d); end
    @(posedge clock);
    @(negedge clock);
    chk("c_rvalid", 32'(c_rvalid), 32'(e_rvalid));
    if (e_rvalid) begin
      chk("c_rdata", c_rdata, e_rdata);
      chk("c_raddress", c_raddress, e_raddr);
    end
    chk("msg_out", 32'(msg_out), 32'(e_msg));
    if (e_msg != NO_REQ) chk("address_out", address_out, e_addr);
    if (e_msg == WB_REQ) chk("data_out", data_out, e_data);
  endtask

  task automatic idle_step(input logic [2:0] mi, input logic [31:0] ai, input logic [31:0] di);
    step(1'b0, 1'b0, 32'h0, 32'h0, mi, ai, di);
  endtask

  // Complete all outstanding work with prompt memory responses.
  task automatic drain_all();
    int n = 0;
    while ((mq_a.size() != 0 || m_wait != 0) && n < 100) begin
      if (e_msg == R_REQ) idle_step(MEM_SENT, e_addr, $urandom);
      else if (e_msg == WB_REQ) idle_step(MEM_READY, 32'h0, 32'h0);
      else idle_step(MEM_NO_MSG, 32'h0, 32'h0);
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  // Called with the clock low; asserts reset asynchronously and checks at once.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_msg_out", 32'(msg_out), 32'h0);
    chk("rst_address_out", address_out, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_c_raddress", c_raddress, 32'h0);
    m_wait = 0; e_msg = NO_REQ; e_rvalid = 1'b0;
    mq_a.delete(); mq_d.delete();
    c_valid = 1'b0; msg_in = MEM_NO_MSG;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic v, w;
    logic [31:0] a, d, ai, di;
    logic [2:0] mi;
    int r;

    #2;
    apply_reset();

    // Read miss with delayed MEM_SENT
    step(1'b1, 1'b0, 32'h100, 32'h0, MEM_NO_MSG, 32'h0, 32'h0);
    chk("r042_req", 32'(msg_out), 32'(R_REQ));
    chk("r042_addr", address_out, 32'h100);
    idle_step(MEM_NO_MSG, 32'h0, 32'h0);
    idle_step(MEM_NO_MSG, 32'h0, 32'h0);
    idle_step(MEM_SENT, 32'h100, 32'hDEADBEEF);
    chk("r042_rvalid", 32'(c_rvalid), 32'h1);
    chk("r042_rdata", c_rdata, 32'hDEADBEEF);
    chk("r042_raddr", c_raddress, 32'h100);
    drain_all();

    // Forwarding from the buffer
    step(1'b1, 1'b1, 32'h200, 32'h11, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h200, 32'h0, MEM_NO_MSG, 32'h0, 32'h0);
    chk("r043_rvalid", 32'(c_rvalid), 32'h1);
    chk("r043_rdata", c_rdata, 32'h11);
    chk("r043_no_rreq", 32'(msg_out), 32'(NO_REQ));
    drain_all();

    // Same-address writes: youngest forwarded, drained in order
    drain_log.delete();
    step(1'b1, 1'b1, 32'h10, 32'hA, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h10, 32'hB, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h10, 32'h0, MEM_READY, 32'h0, 32'h0);
    chk("r044_busy_ready", 32'(last_ready), 32'h0);
    step(1'b1, 1'b0, 32'h10, 32'h0, MEM_NO_MSG, 32'h0, 32'h0);
    chk("r044_rdata", c_rdata, 32'hB);
    drain_all();
    chk("r044_drain_cnt", 32'(drain_log.size()), 32'd2);
    if (drain_log.size() == 2) begin
      chk("r044_drain0", drain_log[0], 32'hA);
      chk("r044_drain1", drain_log[1], 32'hB);
    end

    // Full buffer back-pressure
    step(1'b1, 1'b1, 32'h20, 32'h1, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h24, 32'h2, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h28, 32'h3, MEM_NO_MSG, 32'h0, 32'h0);
    chk("r045_full_ready", 32'(last_ready), 32'h0);
    step(1'b1, 1'b1, 32'h28, 32'h3, MEM_READY, 32'h0, 32'h0);
    chk("r045_nobypass", 32'(last_ready), 32'h0);
    step(1'b1, 1'b1, 32'h28, 32'h3, MEM_NO_MSG, 32'h0, 32'h0);
    chk("r045_accept", 32'(last_ready), 32'h1);
    drain_all();

    // Reset in RD_WAIT with two buffered entries
    step(1'b1, 1'b0, 32'h300, 32'h0, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h400, 32'h5, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h404, 32'h6, MEM_NO_MSG, 32'h0, 32'h0);
    apply_reset();
    idle_step(MEM_SENT, 32'h300, 32'h77);
    chk("r046_late_sent", 32'(c_rvalid), 32'h0);
    chk("r046_no_drain", 32'(msg_out), 32'(NO_REQ));
    step(1'b1, 1'b0, 32'h400, 32'h0, MEM_NO_MSG, 32'h0, 32'h0);
    chk("r046_buf_empty", 32'(msg_out), 32'(R_REQ));
    drain_all();

    // Read miss wins over a pending drain
    step(1'b1, 1'b1, 32'h500, 32'h9, MEM_NO_MSG, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h600, 32'h0, MEM_NO_MSG, 32'h0, 32'h0);
    chk("r047_rreq_first", 32'(msg_out), 32'(R_REQ));
    idle_step(MEM_SENT, 32'h600, 32'h1234);
    chk("r047_wb_next", 32'(msg_out), 32'(WB_REQ));
    chk("r047_wb_addr", address_out, 32'h500);
    chk("r047_rdata", c_rdata, 32'h1234);
    drain_all();

    // Randomized traffic with noisy and mismatched memory responses
    for (int n = 0; n < 3000; n++) begin
      v  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 3)) << 4;
      d  = $urandom;
      mi = MEM_NO_MSG;
      ai = 32'($urandom_range(0, 3)) << 4;
      di = $urandom;
      r  = int'($urandom_range(0, 7));
      if (e_msg == R_REQ && r < 3) begin
        mi = MEM_SENT;
        ai = (r == 0) ? (e_addr ^ 32'h4) : e_addr;
      end else if (e_msg == WB_REQ && r < 3) begin
        mi = MEM_READY;
      end else if (r == 7) begin
        mi = 3'($urandom_range(0, 2));
      end
      step(v, w, a, d, mi, ai, di);
    end
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
